// File: rtl/airlock_pkg.sv
// Shared encodings, direction codes and default timing for the airlock chamber sequencer.
package airlock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAC  = 3'd1,
    OUTER = 3'd2,
    PRESS = 3'd3,
    INNER = 3'd4
  } state_t;

  localparam logic DIR_ARRIVE = 1'b0;
  localparam logic DIR_DEPART = 1'b1;

  localparam int DEF_CLK_PER_SEC = 50_000_000;
  localparam int DEF_PRE_W       = 26;
  localparam int DEF_PRESS_SECS  = 7;
  localparam int DEF_DOOR_SECS   = 5;
  localparam int DEF_SEC_W       = 4;

  typedef struct packed {
    logic outerOpen;
    logic innerOpen;
    logic pumpUp;
    logic pumpDown;
  } drive_t;

  // Exactly one actuator per active state; this is what makes the interlocks hold by construction.
  function automatic drive_t driveOf(state_t s);
    drive_t d;
    d = '0;
    case (s)
      EVAC:    d.pumpDown  = 1'b1;
      OUTER:   d.outerOpen = 1'b1;
      PRESS:   d.pumpUp    = 1'b1;
      INNER:   d.innerOpen = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// Request levels in, chamber actuator commands and status out.
interface airlock_sequencer_if #(parameter int SEC_W = 4);
  logic             arrive;
  logic             depart;
  logic             outer_open;
  logic             inner_open;
  logic             pump_up;
  logic             pump_down;
  logic             busy;
  logic             dir;
  logic [SEC_W-1:0] secs_left;
  logic [2:0]       state_o;

  modport master (
    output arrive, depart,
    input  outer_open, inner_open, pump_up, pump_down, busy, dir, secs_left, state_o
  );

  modport slave (
    input  arrive, depart,
    output outer_open, inner_open, pump_up, pump_down, busy, dir, secs_left, state_o
  );
endinterface

// File: rtl/airlock_sequencer_sec_timer.sv
// One-second prescaler plus whole-seconds down-counter; done flags the last wrap of a phase.
module sec_timer #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int PRE_W       = 26,
  parameter int SEC_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  output logic [SEC_W-1:0] secs_left,
  output logic             done
);

  logic [PRE_W-1:0] pre;
  logic             wrap;

  assign wrap = (pre == PRE_W'(CLK_PER_SEC - 1));
  // Decoded from registers so the FSM can load the next phase on this very edge.
  assign done = wrap && (secs_left == SEC_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= '0;
      secs_left <= '0;
    end else if (load) begin
      pre       <= '0;
      secs_left <= load_val;
    end else if (secs_left != '0) begin
      if (wrap) begin
        pre       <= '0;
        secs_left <= secs_left - SEC_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: edge-detected requests start timed, interlocked door/pump sequences.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int PRE_W       = DEF_PRE_W,
  parameter int PRESS_SECS  = DEF_PRESS_SECS,
  parameter int DOOR_SECS   = DEF_DOOR_SECS,
  parameter int SEC_W       = DEF_SEC_W
) (
  input logic               clk,
  input logic               rst,
  airlock_sequencer_if.slave bus
);

  state_t           state, nextState;
  logic             arriveQ, departQ, riseA, riseD;
  logic             pendA, pendD, startA, startD;
  logic             dirR, busyR, load, done;
  logic [SEC_W-1:0] loadVal, secsLeft;
  drive_t           drive;

  assign riseA = bus.arrive & ~arriveQ;
  assign riseD = bus.depart & ~departQ;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    startA    = 1'b0;
    startD    = 1'b0;
    case (state)
      IDLE: begin
        startA = riseA | pendA;
        startD = ~startA & (riseD | pendD);
        if (startA)      nextState = EVAC;
        else if (startD) nextState = INNER;
      end
      EVAC:    if (done) nextState = OUTER;
      OUTER:   if (done) nextState = PRESS;
      PRESS:   if (done) nextState = (dirR == DIR_ARRIVE) ? INNER : IDLE;
      INNER:   if (done) nextState = (dirR == DIR_ARRIVE) ? IDLE : EVAC;
      default: nextState = IDLE;
    endcase
  end

  assign load    = (nextState != state) && (nextState != IDLE);
  assign loadVal = (nextState == EVAC || nextState == PRESS) ? SEC_W'(PRESS_SECS)
                                                             : SEC_W'(DOOR_SECS);

  // Actuators are registered from nextState so they switch cleanly on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      arriveQ <= 1'b0;
      departQ <= 1'b0;
      pendA   <= 1'b0;
      pendD   <= 1'b0;
      dirR    <= DIR_ARRIVE;
      busyR   <= 1'b0;
      drive   <= '0;
    end else begin
      arriveQ <= bus.arrive;
      departQ <= bus.depart;
      busyR   <= (nextState != IDLE);
      drive   <= driveOf(nextState);
      if (state == IDLE) begin
        if (startA) begin
          pendA <= 1'b0;
          dirR  <= DIR_ARRIVE;
          if (riseD) pendD <= 1'b1;
        end else if (startD) begin
          pendD <= 1'b0;
          dirR  <= DIR_DEPART;
        end
      end else begin
        if (riseA) pendA <= 1'b1;
        if (riseD) pendD <= 1'b1;
      end
    end
  end

  sec_timer #(
    .CLK_PER_SEC(CLK_PER_SEC),
    .PRE_W      (PRE_W),
    .SEC_W      (SEC_W)
  ) uTimer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (loadVal),
    .secs_left(secsLeft),
    .done     (done)
  );

  assign bus.outer_open = drive.outerOpen;
  assign bus.inner_open = drive.innerOpen;
  assign bus.pump_up    = drive.pumpUp;
  assign bus.pump_down  = drive.pumpDown;
  assign bus.busy       = busyR;
  assign bus.dir        = dirR;
  assign bus.secs_left  = secsLeft;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with a short timebase, plus a random interlock soak.
module tb_airlock_sequencer;

  localparam int CPS   = 4;
  localparam int PRE_W = 3;
  localparam int PSECS = 2;
  localparam int DSECS = 1;
  localparam int SEC_W = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_EVAC = 3'd1, S_OUTER = 3'd2, S_PRESS = 3'd3, S_INNER = 3'd4;
  localparam logic [3:0] O_NONE = 4'b0000, O_EVAC = 4'b0001, O_OUTER = 4'b1000,
                         O_PRESS = 4'b0010, O_INNER = 4'b0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   failCount = 0;
  int   interlockErr = 0;
  int   busyCycles;

  airlock_sequencer_if #(.SEC_W(SEC_W)) bus ();

  airlock_sequencer #(
    .CLK_PER_SEC(CPS),
    .PRE_W      (PRE_W),
    .PRESS_SECS (PSECS),
    .DOOR_SECS  (DSECS),
    .SEC_W      (SEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk)
      !(bus.outer_open && bus.inner_open) &&
      !(bus.pump_up && bus.pump_down) &&
      !((bus.outer_open || bus.inner_open) && (bus.pump_up || bus.pump_down)))
    else interlockErr++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.outer_open, bus.inner_open, bus.pump_up, bus.pump_down};
  endfunction

  task automatic checkIdle(input string tag);
    check({tag, ".state"}, bus.state_o, S_IDLE);
    check({tag, ".outs"}, outs(), O_NONE);
    check({tag, ".busy"}, bus.busy, 1'b0);
    check({tag, ".secs"}, bus.secs_left, 0);
  endtask

  // Checks every cycle of one timed phase, then leaves the bench at the first cycle after it.
  task automatic phase(input string tag, input logic [2:0] s, input logic [3:0] o,
                       input int n, input logic d);
    for (int i = 0; i < n * CPS; i++) begin
      check({tag, ".state"}, bus.state_o, s);
      check({tag, ".outs"}, outs(), o);
      check({tag, ".secs"}, bus.secs_left, n - i / CPS);
      check({tag, ".busy"}, bus.busy, 1'b1);
      check({tag, ".dir"}, bus.dir, d);
      if (bus.busy) busyCycles++;
      tick();
    end
  endtask

  task automatic arrivalSeq(input string tag);
    phase({tag, ".evac"},  S_EVAC,  O_EVAC,  PSECS, 1'b0);
    phase({tag, ".outer"}, S_OUTER, O_OUTER, DSECS, 1'b0);
    phase({tag, ".press"}, S_PRESS, O_PRESS, PSECS, 1'b0);
    phase({tag, ".inner"}, S_INNER, O_INNER, DSECS, 1'b0);
  endtask

  task automatic departureSeq(input string tag);
    phase({tag, ".inner"}, S_INNER, O_INNER, DSECS, 1'b1);
    phase({tag, ".evac"},  S_EVAC,  O_EVAC,  PSECS, 1'b1);
    phase({tag, ".outer"}, S_OUTER, O_OUTER, DSECS, 1'b1);
    phase({tag, ".press"}, S_PRESS, O_PRESS, PSECS, 1'b1);
  endtask

  initial begin
    bus.arrive = 1'b0;
    bus.depart = 1'b0;

    // Reset state
    tick();
    checkIdle("reset");
    check("reset.dir", bus.dir, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    checkIdle("post_reset");

    // Arrival: rise sampled at edge t, EVAC visible right after it
    bus.arrive = 1'b1;
    tick();
    bus.arrive = 1'b0;
    busyCycles = 0;
    arrivalSeq("arr");
    checkIdle("arr.end");
    check("arr.busy_cycles", busyCycles, 24);
    tick();
    checkIdle("arr.stay_idle");

    // Departure
    bus.depart = 1'b1;
    tick();
    bus.depart = 1'b0;
    departureSeq("dep");
    checkIdle("dep.end");
    tick();

    // Simultaneous rises: arrival wins, departure served from IDLE on the next edge
    bus.arrive = 1'b1;
    bus.depart = 1'b1;
    tick();
    bus.arrive = 1'b0;
    bus.depart = 1'b0;
    arrivalSeq("sim.arr");
    checkIdle("sim.gap");
    tick();
    departureSeq("sim.dep");
    checkIdle("sim.end");
    tick();

    // Held arrive plus a depart pulse during OUTER
    bus.arrive = 1'b1;
    tick();
    phase("hold.evac", S_EVAC, O_EVAC, PSECS, 1'b0);
    bus.depart = 1'b1;
    tick();
    bus.depart = 1'b0;
    check("hold.outer_state", bus.state_o, S_OUTER);
    check("hold.outer_secs", bus.secs_left, DSECS);
    tick(); tick(); tick();
    phase("hold.press", S_PRESS, O_PRESS, PSECS, 1'b0);
    phase("hold.inner", S_INNER, O_INNER, DSECS, 1'b0);
    checkIdle("hold.gap");
    tick();
    phase("hold.dep_inner", S_INNER, O_INNER, DSECS, 1'b1);
    bus.arrive = 1'b0;
    phase("hold.dep_evac",  S_EVAC,  O_EVAC,  PSECS, 1'b1);
    phase("hold.dep_outer", S_OUTER, O_OUTER, DSECS, 1'b1);
    phase("hold.dep_press", S_PRESS, O_PRESS, PSECS, 1'b1);
    checkIdle("hold.end");
    for (int i = 0; i < 6; i++) tick();
    checkIdle("hold.no_rearrive");

    // Reset during PRESS with a departure pending
    bus.arrive = 1'b1;
    tick();
    bus.arrive = 1'b0;
    phase("rmid.evac", S_EVAC, O_EVAC, PSECS, 1'b0);
    bus.depart = 1'b1;
    phase("rmid.outer", S_OUTER, O_OUTER, DSECS, 1'b0);
    bus.depart = 1'b0;
    check("rmid.press_state", bus.state_o, S_PRESS);
    check("rmid.press_outs", outs(), O_PRESS);
    tick(); tick();
    rst = 1'b1;
    tick();
    checkIdle("rmid.abort");
    check("rmid.dir", bus.dir, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkIdle("rmid.pend_dropped");

    // Random soak for the interlock property
    for (int i = 0; i < 10000; i++) begin
      bus.arrive = ($urandom_range(0, 15) == 0) ? ~bus.arrive : bus.arrive;
      bus.depart = ($urandom_range(0, 15) == 0) ? ~bus.depart : bus.depart;
      tick();
    end
    check("interlock.violations", interlockErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
